// File: rtl/pulse_led_stretcher_if.sv
// Event/status bundle between an event source and the LED pulse stretcher.
// The master drives events and the overflow clear; the slave reports LED and queue state.
interface pulse_led_stretcher_if #(
  parameter int PEND_W = 4
) ();
  logic              pulse_in;
  logic              clr_ovf;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in,
    output clr_ovf,
    input  led,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    input  clr_ovf,
    output led,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_led_stretcher.sv
// Stretches single-cycle event pulses into visible LED flashes (fixed on-time plus off-gap).
// Events arriving during a flash are queued in a saturating counter and replayed in order.
module pulse_led_stretcher #(
  parameter int ON_CYCLES  = 5000000,
  parameter int GAP_CYCLES = 2500000,
  parameter int PEND_W     = 4
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  pulse_led_stretcher_if.slave  bus
);

  localparam int TMAX    = ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) - 1;
  localparam int TIMER_W = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PEND_W-1:0]  pend_q,  pend_d;
  logic               ovf_q,   ovf_d;
  logic               led_q,   led_d;
  logic               busy_q,  busy_d;
  logic               dec;
  logic               sat;

  // Returns {saturated, next_count}; an increment at full scale is dropped, never wrapped.
  function automatic logic [PEND_W:0] pend_step(
    input logic [PEND_W-1:0] cnt,
    input logic              inc,
    input logic              dec_in
  );
    logic [PEND_W:0] res;
    res = {1'b0, cnt};
    if (inc && !dec_in) begin
      if (cnt == PEND_MAX) res = {1'b1, cnt};
      else                 res = {1'b0, cnt + PEND_W'(1)};
    end else if (!inc && dec_in) begin
      res = {1'b0, cnt - PEND_W'(1)};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pulse_in) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
        end
      end
      ST_ON: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          // A pulse on the exit edge with nothing queued is consumed directly.
          if ((pend_q != '0) || bus.pulse_in) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
            dec     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    sat    = 1'b0;
    if (state_q != ST_IDLE) begin
      {sat, pend_d} = pend_step(pend_q, bus.pulse_in, dec);
    end
    // A fresh overflow takes priority over a simultaneous clear.
    ovf_d  = sat | (ovf_q & ~bus.clr_ovf);
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_led_stretcher.sv
// Self-checking bench for pulse_led_stretcher: directed scenarios with hand-computed values
// plus randomized traffic compared every cycle against an elapsed-time flash model.
module tb_pulse_led_stretcher;
  localparam int ON   = 4;
  localparam int GAP  = 3;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;

  pulse_led_stretcher_if #(.PEND_W(PW)) bus ();

  pulse_led_stretcher #(
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .PEND_W    (PW)
  ) dut (
    .clk_100MHz(clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: a flash is "active" and m_el counts edges since the flash started.
  bit m_active;
  int m_el;
  int m_pend;
  bit m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    check("led",      int'(bus.led),      int'(m_active && (m_el < ON)));
    check("busy",     int'(bus.busy),     int'(m_active));
    check("pending",  int'(bus.pending),  m_pend);
    check("overflow", int'(bus.overflow), int'(m_ovf));
  endtask

  task automatic model_reset();
    m_active = 0; m_el = 0; m_pend = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit p, input bit c);
    bit was_active, dec, sat;
    was_active = m_active;
    dec = 0; sat = 0;
    if (!m_active) begin
      if (p) begin m_active = 1; m_el = 0; end
    end else if (m_el == ON + GAP - 1) begin
      if (m_pend > 0 || p) begin m_el = 0; dec = 1; end
      else m_active = 0;
    end else begin
      m_el++;
    end
    if (was_active) begin
      if (p && !dec && m_pend == PMAX) sat = 1;
      else m_pend = m_pend + int'(p) - int'(dec);
    end
    m_ovf = sat | (m_ovf & ~c);
  endtask

  task automatic cyc(input bit p, input bit c);
    @(negedge clk);
    bus.pulse_in = p;
    bus.clr_ovf  = c;
    model_step(p, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    bus.pulse_in = 1'b0;
    bus.clr_ovf  = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.pulse_in = 1'b0;
    bus.clr_ovf  = 1'b0;
    model_reset();
    #12;
    check("rst_led",  int'(bus.led), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pend", int'(bus.pending), 0);
    check("rst_ovf",  int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single pulse: led E0..E3, busy through E6.
    cyc(1, 0);
    check("single_led_E0", int'(bus.led), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0);
      if (i == 3) check("single_led_E3", int'(bus.led), 1);
      if (i == 4) check("single_led_E4", int'(bus.led), 0);
      if (i == 6) check("single_busy_E6", int'(bus.busy), 1);
      if (i == 7) check("single_busy_E7", int'(bus.busy), 0);
    end

    // Two consecutive pulses.
    for (int i = 0; i <= 16; i++) begin
      cyc(i <= 1, 0);
      if (i == 1)  check("two_pend_E1", int'(bus.pending), 1);
      if (i == 7)  begin
        check("two_led_E7", int'(bus.led), 1);
        check("two_pend_E7", int'(bus.pending), 0);
      end
      if (i == 10) check("two_led_E10", int'(bus.led), 1);
      if (i == 11) check("two_led_E11", int'(bus.led), 0);
      if (i == 13) check("two_busy_E13", int'(bus.busy), 1);
      if (i == 14) check("two_busy_E14", int'(bus.busy), 0);
    end

    // Pulse exactly on the GAP-exit edge with nothing queued.
    for (int i = 0; i <= 16; i++) begin
      cyc(i == 0 || i == 7, 0);
      if (i == 6) check("gapexit_led_E6", int'(bus.led), 0);
      if (i == 7) begin
        check("gapexit_led_E7", int'(bus.led), 1);
        check("gapexit_pend_E7", int'(bus.pending), 0);
      end
    end

    // Saturation, sticky overflow, clear, replay of three flashes.
    for (int i = 0; i <= 30; i++) begin
      cyc(i <= 5, i == 10);
      if (i == 3)  check("sat_pend_E3", int'(bus.pending), 3);
      if (i == 4)  begin
        check("sat_ovf_E4", int'(bus.overflow), 1);
        check("sat_pend_E4", int'(bus.pending), 3);
      end
      if (i == 9)  check("sat_ovf_E9", int'(bus.overflow), 1);
      if (i == 10) check("sat_ovf_E10", int'(bus.overflow), 0);
      if (i == 21) check("sat_led_E21", int'(bus.led), 1);
      if (i == 27) check("sat_busy_E27", int'(bus.busy), 1);
      if (i == 28) check("sat_busy_E28", int'(bus.busy), 0);
    end

    // Clear coincident with an overflowing increment: set wins.
    for (int i = 0; i <= 5; i++) cyc(1, i == 5);
    check("coinc_ovf_E5", int'(bus.overflow), 1);
    drain(35);
    check("coinc_ovf_kept", int'(bus.overflow), 1);

    // Asynchronous reset mid-flash with pending and overflow set.
    cyc(1, 0);
    cyc(1, 0);
    check("rstmid_led_pre", int'(bus.led), 1);
    check("rstmid_pend_pre", int'(bus.pending), 1);
    async_reset();
    check("rstmid_led", int'(bus.led), 0);
    check("rstmid_busy", int'(bus.busy), 0);
    check("rstmid_pend", int'(bus.pending), 0);
    check("rstmid_ovf", int'(bus.overflow), 0);
    for (int i = 0; i <= 7; i++) begin
      cyc(i == 0, 0);
      if (i == 3) check("rstmid_led_E3", int'(bus.led), 1);
      if (i == 4) check("rstmid_led_E4", int'(bus.led), 0);
    end

    // Randomized traffic in bursty and sparse modes, with rare async resets.
    begin
      int thr;
      thr = 30;
      for (int i = 0; i < 3000; i++) begin
        if (i % 60 == 0) begin
          case ($urandom_range(2, 0))
            0: thr = 3;
            1: thr = 25;
            default: thr = 75;
          endcase
        end
        if ($urandom_range(599, 0) == 0) begin
          @(posedge clk);
          async_reset();
        end
        cyc($urandom_range(99, 0) < thr, $urandom_range(24, 0) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
